// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared state encoding and line geometry for the fetch front end
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int LINE_BEATS     = 8;
  localparam int LINE_BYTES     = LINE_BEATS * 8;
  localparam int WORDS_PER_LINE = 2 * LINE_BEATS;
  localparam int LINE_OFF_W     = $clog2(LINE_BYTES);
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);
  localparam int BEAT_IDX_W     = $clog2(LINE_BEATS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RECV  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_line_buffer.sv
// ---------------------------------------------------------------------------
// fetch_line_buffer : one cache line of instruction storage, 64-bit beat
//                     write port and 32-bit word read port
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int BEATS = LINE_BEATS
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [$clog2(BEATS)-1:0]   wr_beat_i,
  input  logic [63:0]                wr_data_i,
  input  logic [$clog2(BEATS):0]     rd_word_i,
  output logic [31:0]                rd_data_o
);

  logic [31:0] mem_q [2*BEATS];

  // Lower half of a beat is the lower-addressed word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{wr_beat_i, 1'b0}] <= wr_data_i[31:0];
      mem_q[{wr_beat_i, 1'b1}] <= wr_data_i[63:32];
    end
  end

  assign rd_data_o = mem_q[rd_word_i];

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer : fetches one line at a time from memory and hands words
//                   to the decoder, following redirects and halting on zero
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer #(
  parameter int LINE_BEATS = 8,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] entry_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [63:0]       resp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              done
);

  import fetch_pkg::*;

  localparam int OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int WIDX_W = $clog2(2 * LINE_BEATS);
  localparam int BIDX_W = $clog2(LINE_BEATS);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(LINE_BEATS - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [BIDX_W-1:0] cnt_q, cnt_d;
  logic              req_valid_q;
  logic              done_q;

  logic [WIDX_W-1:0] w_idx;
  logic [31:0]       w_rdata;
  logic              w_zero;
  logic              w_last_word;
  logic              w_last_beat;
  logic              w_issue;
  logic              w_buf_we;

  assign w_idx       = pc_q[OFF_W-1:2];
  assign w_zero      = (w_rdata == 32'h0);
  assign w_last_word = &w_idx;
  assign w_last_beat = (cnt_q == LAST_BEAT);
  assign w_issue     = (state_q == S_ISSUE) && !w_zero;
  assign w_buf_we    = (state_q == S_RECV) && resp_valid;

  fetch_line_buffer #(
    .BEATS (LINE_BEATS)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (w_buf_we),
    .wr_beat_i (cnt_q),
    .wr_data_i (resp_data),
    .rd_word_i (w_idx),
    .rd_data_o (w_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = entry_pc & WORD_MASK;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A request accepted in the redirect cycle still returns a full line.
        if (redirect_valid) begin
          pc_d    = redirect_pc & WORD_MASK;
          cnt_d   = '0;
          state_d = req_ready ? S_DRAIN : S_REQ;
        end else if (req_ready) begin
          cnt_d   = '0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (resp_valid) cnt_d = cnt_q + 1'b1;
        if (redirect_valid) begin
          pc_d    = redirect_pc & WORD_MASK;
          state_d = (resp_valid && w_last_beat) ? S_REQ : S_DRAIN;
        end else if (resp_valid && w_last_beat) begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (resp_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (w_last_beat) state_d = S_REQ;
        end
        if (redirect_valid) pc_d = redirect_pc & WORD_MASK;
      end
      S_ISSUE: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc & WORD_MASK;
          state_d = S_REQ;
        end else if (w_zero) begin
          state_d = S_DONE;
        end else if (instr_ready) begin
          pc_d = pc_q + WORD_STEP;
          if (w_last_word) state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      req_valid_q <= (state_d == S_REQ);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign req_valid   = req_valid_q;
  assign req_addr    = pc_q & LINE_MASK;
  assign instr_valid = w_issue;
  assign instr       = w_issue ? w_rdata : 32'h0;
  assign instr_pc    = pc_q;
  assign done        = done_q;

endmodule

`default_nettype wire
